// File: rtl/avalon_multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH prescaled down-counters with per-channel IRQs.
// Optional input capture on capture_in is compiled in when TIMER_CAPTURE_EN is defined.
module avalon_multi_interval_timer #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h1312CF,
  localparam int         AW           = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef TIMER_CAPTURE_EN
  input  logic [NUM_CH-1:0] capture_in,
`endif
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_ch
);

  localparam int             SEL_W   = AW - 1;
  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  typedef enum logic [1:0] {
    REG_STATUS   = 2'd0,
    REG_CONTROL  = 2'd1,
    REG_PERIOD   = 2'd2,
    REG_SNAPSHOT = 2'd3
  } reg_e;

  typedef struct packed {
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] snapshot;
    logic [7:0]       presc_cnt;
    logic [7:0]       presc;
    logic             ito;
    logic             cont;
    logic             icap;
    logic             run;
    logic             to;
    logic             cap;
  } ch_t;

  localparam ch_t CH_RST = '{counter: RST_CNT, period: RST_CNT, default: '0};

  ch_t               ch_q [NUM_CH];
  ch_t               ch_d [NUM_CH];
  logic [AW:0]       addr_ext;
  logic [SEL_W-1:0]  ch_sel;
  reg_e              reg_sel;
  logic              wr;
  logic [NUM_CH-1:0] hit, tick, timeout, cap_edge;
  logic [31:0]       rd_mux;

  // Zero-extended so the channel field is at least one bit wide even when NUM_CH is 1.
  assign addr_ext = {1'b0, address};
  assign ch_sel   = addr_ext[AW:2];
  assign reg_sel  = reg_e'(address[1:0]);
  assign wr       = chipselect & ~write_n;

`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0] cap_meta, cap_sync, cap_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_meta <= '0;
      cap_sync <= '0;
      cap_prev <= '0;
    end else begin
      cap_meta <= capture_in;
      cap_sync <= cap_meta;
      cap_prev <= cap_sync;
    end
  end

  assign cap_edge = cap_sync & ~cap_prev;
`else
  assign cap_edge = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]     = wr && (ch_sel == SEL_W'(i));
      tick[i]    = ch_q[i].run && (ch_q[i].presc_cnt == ch_q[i].presc);
      timeout[i] = tick[i] && (ch_q[i].counter == '0);
    end
  end

  // NOTE: combinational next-state uses blocking assignments, starting from the held value so
  // no path can infer a latch; later statements override earlier ones, which encodes precedence.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i] = ch_q[i];

      if (ch_q[i].run) ch_d[i].presc_cnt = tick[i] ? 8'd0 : ch_q[i].presc_cnt + 8'd1;
      if (timeout[i]) begin
        ch_d[i].counter = ch_q[i].period;
        ch_d[i].to      = 1'b1;
        if (!ch_q[i].cont) ch_d[i].run = 1'b0;
      end else if (tick[i]) begin
        ch_d[i].counter = ch_q[i].counter - CNT_W'(1);
      end

      if (hit[i]) begin
        case (reg_sel)
          REG_STATUS: begin
            // A flag being set this cycle survives a simultaneous clear.
            if (writedata[0] && !timeout[i])  ch_d[i].to  = 1'b0;
            if (writedata[2] && !cap_edge[i]) ch_d[i].cap = 1'b0;
          end
          REG_CONTROL: begin
            ch_d[i].ito   = writedata[0];
            ch_d[i].cont  = writedata[1];
            ch_d[i].presc = writedata[15:8];
`ifdef TIMER_CAPTURE_EN
            ch_d[i].icap  = writedata[4];
`endif
            if (writedata[2]) begin
              ch_d[i].run       = 1'b1;
              ch_d[i].presc_cnt = 8'd0;
            end else if (writedata[3]) begin
              ch_d[i].run = 1'b0;
            end
          end
          REG_PERIOD: begin
            ch_d[i].period    = writedata[CNT_W-1:0];
            ch_d[i].counter   = writedata[CNT_W-1:0];
            ch_d[i].presc_cnt = 8'd0;
            ch_d[i].run       = 1'b0;
          end
          REG_SNAPSHOT: ch_d[i].snapshot = ch_q[i].counter;
          default: ;
        endcase
      end

      if (cap_edge[i]) begin
        ch_d[i].snapshot = ch_q[i].counter;
        ch_d[i].cap      = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        case (reg_sel)
          REG_STATUS:   rd_mux = {29'd0, ch_q[i].cap, ch_q[i].run, ch_q[i].to};
          REG_CONTROL:  rd_mux = {16'd0, ch_q[i].presc, 3'd0, ch_q[i].icap, 2'd0,
                                  ch_q[i].cont, ch_q[i].ito};
          REG_PERIOD:   rd_mux = 32'(ch_q[i].period);
          REG_SNAPSHOT: rd_mux = 32'(ch_q[i].snapshot);
          default:      rd_mux = '0;
        endcase
      end
    end
  end

  // NOTE: the channel register array is fully reset; every field is software-visible state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= CH_RST;
    end else begin
      readdata <= rd_mux;
      ch_q     <= ch_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      irq_ch[i] = (ch_q[i].to & ch_q[i].ito) | (ch_q[i].cap & ch_q[i].icap);
  end

  assign irq = |irq_ch;

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// Directed bench for avalon_multi_interval_timer (NUM_CH=2, CNT_W=32); expected values hand-derived.
// Bus tasks are entered just after a falling edge; each one occupies exactly one rising edge.
module tb_avalon_multi_interval_timer;

  localparam int NUM_CH = 2;
  localparam int AW     = 3;
  localparam int R_STA  = 0;
  localparam int R_CTL  = 1;
  localparam int R_PER  = 2;
  localparam int R_SNP  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [AW-1:0]     address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_ch;
`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0] capture_in = '0;
`endif

  int          passed = 0;
  int          total  = 0;
  logic [31:0] rd;

  avalon_multi_interval_timer #(.NUM_CH(NUM_CH), .CNT_W(32), .RESET_PERIOD(32'h1312CF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef TIMER_CAPTURE_EN
    .capture_in (capture_in),
`endif
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_ch     (irq_ch)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    address = AW'((ch << 2) | r); chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    address = AW'((ch << 2) | r); chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    address = AW'(R_PER);
    repeat (3) @(negedge clk);
    total++; if (readdata !== 32'h0) $display("FAIL rst_readdata: got %h want %h", readdata, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else passed++;
    total++; if (irq_ch !== 2'b00) $display("FAIL rst_irq_ch: got %b want 00", irq_ch); else passed++;
    reset_n = 1'b1;
    bus_read(0, R_PER, rd);
    total++; if (rd !== 32'h0013_12CF) $display("FAIL rst_period_ch0: got %h want %h", rd, 32'h0013_12CF); else passed++;
    bus_read(1, R_PER, rd);
    total++; if (rd !== 32'h0013_12CF) $display("FAIL rst_period_ch1: got %h want %h", rd, 32'h0013_12CF); else passed++;
    bus_read(0, R_STA, rd);
    total++; if (rd !== 32'h0) $display("FAIL rst_status_ch0: got %h want %h", rd, 32'h0); else passed++;
    bus_read(1, R_CTL, rd);
    total++; if (rd !== 32'h0) $display("FAIL rst_control_ch1: got %h want %h", rd, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq_after: got %b want 0", irq); else passed++;
  endtask

  task automatic test_continuous;
    logic [31:0] exp_cnt [6] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
    bus_write(0, R_PER, 32'd4);
    bus_write(0, R_CTL, 32'h7);
    // TO (and therefore irq_ch[0]) must appear on exactly the 5th edge after START.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (irq_ch[0] !== 1'(k == 5)) $display("FAIL cont_irq_edge%0d: got %b want %b", k, irq_ch[0], 1'(k == 5));
      else passed++;
    end
    total++; if (irq !== 1'b1) $display("FAIL cont_irq_or: got %b want 1", irq); else passed++;
    bus_write(0, R_STA, 32'h1);
    total++; if (irq !== 1'b0) $display("FAIL cont_w1c_irq: got %b want 0", irq); else passed++;
    bus_read(0, R_STA, rd);
    total++; if (rd !== 32'h2) $display("FAIL cont_w1c_status: got %h want %h", rd, 32'h2); else passed++;
    // A snapshot j+1 edges after START captures the count left by edge j.
    for (int j = 0; j < 6; j++) begin
      bus_write(0, R_PER, 32'd4);
      bus_write(0, R_CTL, 32'h7);
      idle(j);
      bus_write(0, R_SNP, 32'h0);
      bus_read(0, R_SNP, rd);
      total++;
      if (rd !== exp_cnt[j]) $display("FAIL cont_seq%0d: got %h want %h", j, rd, exp_cnt[j]);
      else passed++;
    end
  endtask

  task automatic test_one_shot;
    bus_write(1, R_PER, 32'd2);
    bus_write(1, R_CTL, 32'h0305);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (irq_ch[1] !== 1'(k == 12)) $display("FAIL oneshot_irq_edge%0d: got %b want %b", k, irq_ch[1], 1'(k == 12));
      else passed++;
    end
    bus_read(1, R_STA, rd);
    total++; if (rd !== 32'h1) $display("FAIL oneshot_status: got %h want %h", rd, 32'h1); else passed++;
    bus_read(1, R_CTL, rd);
    total++; if (rd !== 32'h0301) $display("FAIL oneshot_control: got %h want %h", rd, 32'h0301); else passed++;
    bus_write(1, R_SNP, 32'h0);
    bus_read(1, R_SNP, rd);
    total++; if (rd !== 32'd2) $display("FAIL oneshot_counter: got %h want %h", rd, 32'd2); else passed++;
    bus_read(0, R_PER, rd);
    total++; if (rd !== 32'd4) $display("FAIL oneshot_ch0_period: got %h want %h", rd, 32'd4); else passed++;
    bus_read(0, R_CTL, rd);
    total++; if (rd !== 32'h3) $display("FAIL oneshot_ch0_control: got %h want %h", rd, 32'h3); else passed++;
    bus_read(0, R_STA, rd);
    total++; if (rd[1] !== 1'b1) $display("FAIL oneshot_ch0_run: got %b want 1", rd[1]); else passed++;
  endtask

  task automatic test_simultaneous;
    bus_write(1, R_PER, 32'd2);
    bus_write(1, R_STA, 32'h1);
    bus_write(1, R_CTL, 32'hC);
    bus_read(1, R_STA, rd);
    total++; if (rd !== 32'h2) $display("FAIL sim_start_stop: got %h want %h", rd, 32'h2); else passed++;
    // PRESC=0, counter 2: timeout lands on the 3rd edge after START.
    bus_write(1, R_PER, 32'd2);
    bus_write(1, R_STA, 32'h1);
    bus_write(1, R_CTL, 32'h4);
    idle(2);
    bus_write(1, R_STA, 32'h1);
    bus_read(1, R_STA, rd);
    total++; if (rd !== 32'h1) $display("FAIL sim_w1c_vs_timeout: got %h want %h", rd, 32'h1); else passed++;
    bus_write(1, R_PER, 32'd2);
    bus_write(1, R_STA, 32'h1);
    bus_write(1, R_CTL, 32'h4);
    idle(2);
    bus_write(1, R_CTL, 32'h4);
    bus_read(1, R_STA, rd);
    total++; if (rd !== 32'h3) $display("FAIL sim_start_vs_oneshot: got %h want %h", rd, 32'h3); else passed++;
  endtask

  task automatic test_mid_count;
    bus_write(0, R_PER, 32'd100);
    bus_write(0, R_STA, 32'h1);
    bus_write(0, R_CTL, 32'h6);
    idle(5);
    bus_write(0, R_PER, 32'd10);
    bus_read(0, R_STA, rd);
    total++; if (rd !== 32'h0) $display("FAIL mid_period_stop: got %h want %h", rd, 32'h0); else passed++;
    bus_write(0, R_SNP, 32'h0);
    bus_read(0, R_SNP, rd);
    total++; if (rd !== 32'd10) $display("FAIL mid_snapshot: got %h want %h", rd, 32'd10); else passed++;
    bus_write(0, R_CTL, 32'h6);
    bus_write(1, R_CTL, 32'h1);
    total++; if (irq !== 1'b1) $display("FAIL mid_irq_pre_reset: got %b want 1", irq); else passed++;
    bus_read(0, R_PER, rd);
    total++; if (rd !== 32'd10) $display("FAIL mid_period_read: got %h want %h", rd, 32'd10); else passed++;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    total++; if (readdata !== 32'h0) $display("FAIL mid_rst_readdata: got %h want %h", readdata, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL mid_rst_irq: got %b want 0", irq); else passed++;
    total++; if (irq_ch !== 2'b00) $display("FAIL mid_rst_irq_ch: got %b want 00", irq_ch); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(0, R_PER, rd);
    total++; if (rd !== 32'h0013_12CF) $display("FAIL mid_rst_period: got %h want %h", rd, 32'h0013_12CF); else passed++;
    bus_read(0, R_CTL, rd);
    total++; if (rd !== 32'h0) $display("FAIL mid_rst_control: got %h want %h", rd, 32'h0); else passed++;
    bus_read(1, R_STA, rd);
    total++; if (rd !== 32'h0) $display("FAIL mid_rst_status_ch1: got %h want %h", rd, 32'h0); else passed++;
    bus_read(0, R_SNP, rd);
    total++; if (rd !== 32'h0) $display("FAIL mid_rst_snapshot: got %h want %h", rd, 32'h0); else passed++;
    bus_write(0, R_SNP, 32'h0);
    bus_read(0, R_SNP, rd);
    total++; if (rd !== 32'h0013_12CF) $display("FAIL mid_rst_counter: got %h want %h", rd, 32'h0013_12CF); else passed++;
  endtask

`ifdef TIMER_CAPTURE_EN
  task automatic test_capture;
    bus_write(0, R_PER, 32'd1000);
    bus_write(0, R_STA, 32'h7);
    bus_write(0, R_CTL, 32'h16);
    idle(10);
    // Edge seen on the 2nd rising edge, snapshot loads on the 3rd with the count after edge 12.
    capture_in[0] = 1'b1;
    idle(3);
    total++; if (irq !== 1'b1) $display("FAIL cap_irq: got %b want 1", irq); else passed++;
    bus_read(0, R_SNP, rd);
    total++; if (rd !== 32'd988) $display("FAIL cap_snapshot: got %h want %h", rd, 32'd988); else passed++;
    bus_read(0, R_STA, rd);
    total++; if (rd !== 32'h6) $display("FAIL cap_status: got %h want %h", rd, 32'h6); else passed++;
    capture_in[0] = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_one_shot();
    test_simultaneous();
    test_mid_count();
`ifdef TIMER_CAPTURE_EN
    test_capture();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
